// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk_i cycles,
// emits a one-cycle strobe per completed cycle and flags a stuck-low / stuck-high input.
module pwm_capture #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 32'd1000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pwm_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic [1:0]       stuck_o
);

  localparam int unsigned EDGE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [EDGE_W-1:0] TO_MAX = EDGE_W'(TIMEOUT_CYC);
  localparam logic [EDGE_W-1:0] TO_PRE = EDGE_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_MEAS_HIGH = 2'd2,
    S_MEAS_LOW  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_sync1, r_sync2, r_sync3;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_hcnt, w_hcnt_nxt;
  logic [CNT_W-1:0]   r_period, w_period_nxt;
  logic [CNT_W-1:0]   r_high, w_high_nxt;
  logic               r_valid, w_valid_nxt;
  logic [1:0]         r_stuck, w_stuck_nxt;
  logic [EDGE_W-1:0]  r_edge_cnt, w_edge_cnt_nxt;
  logic               w_rise, w_fall, w_edge, w_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pwm_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;
  assign w_edge = w_rise | w_fall;
  // Fires once, on the cycle the quiet-time counter would reach TIMEOUT_CYC; an edge always wins.
  assign w_timeout = enable_i & ~w_edge & (r_state != S_IDLE) & (r_edge_cnt == TO_PRE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_stuck    <= 2'b00;
      r_edge_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_period   <= w_period_nxt;
      r_high     <= w_high_nxt;
      r_valid    <= w_valid_nxt;
      r_stuck    <= w_stuck_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_hcnt_nxt     = r_hcnt;
    w_period_nxt   = r_period;
    w_high_nxt     = r_high;
    w_valid_nxt    = 1'b0;
    w_stuck_nxt    = r_stuck;
    w_edge_cnt_nxt = r_edge_cnt;

    if (!enable_i) begin
      // Abort: results and stuck flag are held, everything else restarts.
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = '0;
      w_hcnt_nxt     = '0;
      w_edge_cnt_nxt = '0;
    end else begin
      if (w_edge) begin
        w_edge_cnt_nxt = '0;
        w_stuck_nxt    = 2'b00;
      end else if (r_edge_cnt != TO_MAX) begin
        w_edge_cnt_nxt = r_edge_cnt + EDGE_W'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT_RISE;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
          w_stuck_nxt = 2'b00;
        end
        S_WAIT_RISE: begin
          if (w_rise) begin
            w_state_nxt = S_MEAS_HIGH;
            w_cnt_nxt   = CNT_ONE;
            w_hcnt_nxt  = CNT_ONE;
          end
        end
        S_MEAS_HIGH: begin
          w_cnt_nxt = sat_inc(r_cnt);
          if (w_fall) begin
            w_state_nxt = S_MEAS_LOW;
          end else begin
            w_hcnt_nxt = sat_inc(r_hcnt);
          end
        end
        S_MEAS_LOW: begin
          if (w_rise) begin
            // Close this cycle and open the next one with no gap.
            w_period_nxt = r_cnt;
            w_high_nxt   = r_hcnt;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_MEAS_HIGH;
            w_cnt_nxt    = CNT_ONE;
            w_hcnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_timeout) begin
        w_stuck_nxt = {r_sync2, ~r_sync2};
        w_state_nxt = S_WAIT_RISE;
        w_cnt_nxt   = '0;
        w_hcnt_nxt  = '0;
      end
    end
  end

  assign period_o     = r_period;
  assign high_o       = r_high;
  assign meas_valid_o = r_valid;
  assign stuck_o      = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of PWM bursts checked through a strobe scoreboard,
// plus hand sequences for timeout, enable abort and asynchronous reset.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO    = 50;

  logic             clk_i, rst_i, pwm_i, enable_i;
  logic [CNT_W-1:0] period_o, high_o;
  logic             meas_valid_o;
  logic [1:0]       stuck_o;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pwm_i(pwm_i), .enable_i(enable_i),
    .period_o(period_o), .high_o(high_o), .meas_valid_o(meas_valid_o), .stuck_o(stuck_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int               p;
    int               h;
    int               n;
    bit               new_run;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    bit               chk_gap;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               total = 0;
  int               bad   = 0;
  int               cyc   = 0;
  int               last_strobe = 0;
  bit               have_prev = 0;
  int               run_pushes = 0;
  logic [CNT_W-1:0] prev_p, prev_h;
  vec_t             vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a driven rise completes the previous cycle, whose result is then expected.
  task automatic start_cycle(input logic [CNT_W-1:0] ep, input logic [CNT_W-1:0] eh);
    exp_t e;
    if (have_prev) begin
      e.period  = prev_p;
      e.high    = prev_h;
      e.chk_gap = (run_pushes > 0);
      sb_q.push_back(e);
      run_pushes++;
    end
    have_prev = 1'b1;
    prev_p    = ep;
    prev_h    = eh;
    pwm_i     = 1'b1;
  endtask

  task automatic drive_cycle(input int p, input int h,
                             input logic [CNT_W-1:0] ep, input logic [CNT_W-1:0] eh);
    start_cycle(ep, eh);
    repeat (h) @(negedge clk_i);
    pwm_i = 1'b0;
    repeat (p - h) @(negedge clk_i);
  endtask

  task automatic new_run_wait();
    repeat (TO + 10) @(negedge clk_i);
    chk("stuck_low_idle", 32'(stuck_o), 32'd1);
    have_prev  = 1'b0;
    run_pushes = 0;
  endtask

  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (meas_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got period=%0d high=%0d expected no strobe (t=%0t)",
                 period_o, high_o, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("period", 32'(period_o), 32'(mon_e.period));
        chk("high", 32'(high_o), 32'(mon_e.high));
        if (mon_e.chk_gap) chk("strobe_gap", 32'(cyc - last_strobe), 32'(mon_e.period));
      end
      last_strobe = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{p: 10, h: 3,  n: 6, new_run: 1'b1, exp_period: 16'd10, exp_high: 16'd3};
    vecs[1] = '{p: 20, h: 15, n: 4, new_run: 1'b0, exp_period: 16'd20, exp_high: 16'd15};
    vecs[2] = '{p: 8,  h: 1,  n: 5, new_run: 1'b1, exp_period: 16'd8,  exp_high: 16'd1};
    vecs[3] = '{p: 2,  h: 1,  n: 8, new_run: 1'b1, exp_period: 16'd2,  exp_high: 16'd1};
    vecs[4] = '{p: 13, h: 7,  n: 4, new_run: 1'b1, exp_period: 16'd13, exp_high: 16'd7};

    rst_i = 1'b1; enable_i = 1'b0; pwm_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_period", 32'(period_o), 32'd0);
    chk("rst_high", 32'(high_o), 32'd0);
    chk("rst_valid", 32'(meas_valid_o), 32'd0);
    chk("rst_stuck", 32'(stuck_o), 32'd0);
    rst_i = 1'b0;
    enable_i = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].new_run) new_run_wait();
      repeat (vecs[i].n) drive_cycle(vecs[i].p, vecs[i].h, vecs[i].exp_period, vecs[i].exp_high);
    end

    // Stuck high: flag appears exactly TO cycles after the registered rise, cleared by the fall.
    new_run_wait();
    pwm_i = 1'b1;
    for (int n = 1; n <= 53; n++) begin
      @(posedge clk_i); #1;
      if (n == 3)  chk("stuck_cleared_by_rise", 32'(stuck_o), 32'd0);
      if (n == 52) chk("stuck_high_early", 32'(stuck_o), 32'd0);
      if (n == 53) chk("stuck_high", 32'(stuck_o), 32'd2);
    end
    @(negedge clk_i);
    pwm_i = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk_i); #1;
      if (n == 2) chk("stuck_high_hold", 32'(stuck_o), 32'd2);
      if (n == 3) chk("stuck_cleared_by_fall", 32'(stuck_o), 32'd0);
    end
    @(negedge clk_i);

    // Enable dropped during the low phase, raised again 5 cycles later mid-pulse.
    new_run_wait();
    repeat (3) drive_cycle(10, 3, 16'd10, 16'd3);
    start_cycle(16'd10, 16'd3);
    repeat (3) @(negedge clk_i);
    pwm_i = 1'b0;
    repeat (5) @(negedge clk_i);
    enable_i  = 1'b0;
    have_prev = 1'b0;
    repeat (2) @(negedge clk_i);
    pwm_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("dis_hold_period", 32'(period_o), 32'd10);
    chk("dis_hold_high", 32'(high_o), 32'd3);
    enable_i = 1'b1;
    pwm_i    = 1'b0;
    repeat (7) @(negedge clk_i);
    run_pushes = 0;
    repeat (3) drive_cycle(10, 3, 16'd10, 16'd3);

    // Asynchronous reset in the middle of a high phase.
    new_run_wait();
    repeat (2) drive_cycle(12, 6, 16'd12, 16'd6);
    start_cycle(16'd12, 16'd6);
    repeat (4) @(negedge clk_i);
    chk("pre_rst_period", 32'(period_o), 32'd12);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_period", 32'(period_o), 32'd0);
    chk("arst_high", 32'(high_o), 32'd0);
    chk("arst_stuck", 32'(stuck_o), 32'd0);
    pwm_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i     = 1'b0;
    have_prev = 1'b0;
    new_run_wait();
    chk("post_rst_period", 32'(period_o), 32'd0);
    repeat (3) drive_cycle(9, 4, 16'd9, 16'd4);

    repeat (10) @(negedge clk_i);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
